// File: rtl/wdg_rst_ctl_pkg.sv
// Shared types for the watchdog / software reset-request generator.
package rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } wdg_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SOFT = 2'b01,
    CAUSE_WDG  = 2'b10
  } rst_cause_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wdg_rst_ctl_rise_det.sv
// One-flop rising-edge detector with synchronous active-low reset.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/wdg_rst_ctl.sv
// Reset-request generator: watchdog timeout or software request -> fixed low pulse + holdoff.
// Optional early-warning flag built only when WDG_WARN_EN is defined.
module wdg_rst_ctl
  import rst_pkg::*;
#(
  parameter int WDG_CYCLES     = 200000000,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       wdg_en_in,
  input  logic       wdg_kick_in,
  input  logic       soft_rst_req_in,
  output logic       rst_req_n_out,
  output logic       busy_out,
  output logic [1:0] cause_out,
  output logic       wdg_warn_out
);

  localparam int CW = $clog2(max3(WDG_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES)) + 1;
  localparam logic [CW-1:0] WDG_LAST   = CW'(WDG_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  initial begin
    if (WDG_CYCLES < 2)     $error("wdg_rst_ctl: WDG_CYCLES must be >= 2");
    if (PULSE_CYCLES < 4)   $error("wdg_rst_ctl: PULSE_CYCLES must be >= 4");
    if (HOLDOFF_CYCLES < 1) $error("wdg_rst_ctl: HOLDOFF_CYCLES must be >= 1");
  end

  wdg_state_t    state, state_nxt;
  rst_cause_t    cause, cause_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          soft_rise;
  logic          rst_req_n;
  logic          busy;

  rise_det u_soft_rise (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .din   (soft_rst_req_in),
    .rise  (soft_rise)
  );

  // A soft rise outranks everything outside PULSE/HOLDOFF; a kick outranks terminal count.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (soft_rise) begin
          state_nxt = PULSE;
          cause_nxt = CAUSE_SOFT;
        end else if (wdg_en_in) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (soft_rise) begin
          state_nxt = PULSE;
          cause_nxt = CAUSE_SOFT;
        end else if (!wdg_en_in) begin
          state_nxt = IDLE;
        end else if (wdg_kick_in) begin
          cnt_nxt = '0;
        end else if (cnt == WDG_LAST) begin
          state_nxt = PULSE;
          cause_nxt = CAUSE_WDG;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = wdg_en_in ? ARMED : IDLE;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cause_nxt = CAUSE_NONE;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they are clean flops aligned with the state.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      cause     <= CAUSE_NONE;
      cnt       <= '0;
      rst_req_n <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cause     <= cause_nxt;
      cnt       <= cnt_nxt;
      rst_req_n <= (state_nxt != PULSE);
      busy      <= (state_nxt == PULSE) || (state_nxt == HOLDOFF);
    end
  end

  assign rst_req_n_out = rst_req_n;
  assign busy_out      = busy;
  assign cause_out     = cause;

`ifdef WDG_WARN_EN
  localparam logic [CW-1:0] WARN_AT = CW'(WDG_CYCLES / 2);
  logic warn;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) warn <= 1'b0;
    else           warn <= (state_nxt == ARMED) && (cnt_nxt >= WARN_AT);
  end

  assign wdg_warn_out = warn;
`else
  assign wdg_warn_out = 1'b0;
`endif

endmodule

// File: tb/tb_wdg_rst_ctl.sv
// Scoreboard bench for wdg_rst_ctl: a busy-window reference model predicts every cycle's outputs.
module tb_wdg_rst_ctl;

  localparam int W = 100;
  localparam int P = 8;
  localparam int H = 32;

  typedef struct packed {
    logic       req_n;
    logic       busy;
    logic [1:0] cause;
    logic       warn;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_n_in, wdg_en_in, wdg_kick_in, soft_rst_req_in;
  logic       rst_req_n_out, busy_out, wdg_warn_out;
  logic [1:0] cause_out;

  wdg_rst_ctl #(.WDG_CYCLES(W), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .wdg_en_in       (wdg_en_in),
    .wdg_kick_in     (wdg_kick_in),
    .soft_rst_req_in (soft_rst_req_in),
    .rst_req_n_out   (rst_req_n_out),
    .busy_out        (busy_out),
    .cause_out       (cause_out),
    .wdg_warn_out    (wdg_warn_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_act;

  // Model: a busy window of P+H cycles; the request is low during its first P cycles.
  int         m_busy_left = 0;
  int         m_age = 0;
  bit         m_armed = 0;
  bit         m_prev_soft = 0;
  logic [1:0] m_cause = 2'b00;

  int pulses = 0, low_cycles = 0, busy_cycles = 0;
  logic prev_req = 1'b1;

  task automatic model_step(input bit r, input bit e, input bit k, input bit s);
    bit rise;
    if (!r) begin
      m_busy_left = 0; m_age = 0; m_armed = 0; m_prev_soft = 0; m_cause = 2'b00;
    end else begin
      rise = s && !m_prev_soft;
      m_prev_soft = s;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_cause = 2'b00; m_armed = e; m_age = 0;
        end
      end else if (rise) begin
        m_busy_left = P + H; m_cause = 2'b01; m_armed = 0;
      end else if (m_armed) begin
        if (!e) m_armed = 0;
        else if (k) m_age = 0;
        else if (m_age == W - 1) begin
          m_busy_left = P + H; m_cause = 2'b10; m_armed = 0;
        end else m_age++;
      end else if (e) begin
        m_armed = 1; m_age = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.req_n = !(m_busy_left > H);
    x.busy  = (m_busy_left > 0);
    x.cause = m_cause;
`ifdef WDG_WARN_EN
    x.warn  = m_armed && (m_age >= W / 2);
`else
    x.warn  = 1'b0;
`endif
    return x;
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input bit k, input bit s);
    rst_n_in = r; wdg_en_in = e; wdg_kick_in = k; soft_rst_req_in = s;
    model_step(r, e, k, s);
    exp_q.push_back(model_out());
    @(negedge clk_in);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every sampled cycle is scored against the oldest prediction.
  always @(posedge clk_in) begin
    #1;
    if (!rst_req_n_out && prev_req) pulses++;
    if (!rst_req_n_out) low_cycles++;
    if (busy_out) busy_cycles++;
    prev_req = rst_req_n_out;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {rst_req_n_out, busy_out, cause_out, wdg_warn_out};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("[TB] FAIL cycle_out @%0t: got req_n=%b busy=%b cause=%b warn=%b, expected req_n=%b busy=%b cause=%b warn=%b",
                 $time, mon_act.req_n, mon_act.busy, mon_act.cause, mon_act.warn,
                 mon_exp.req_n, mon_exp.busy, mon_exp.cause, mon_exp.warn);
      end
    end
  end

  int p0, l0, b0;
  bit en, kk, ss;

  initial begin
    rst_n_in = 1'b0; wdg_en_in = 1'b0; wdg_kick_in = 1'b0; soft_rst_req_in = 1'b0;
    @(negedge clk_in);

    $display("[TB] scenario 1: reset then idle");
    repeat (5) applyStimulus(0, 0, 0, 0);
    repeat (20) applyStimulus(1, 0, 0, 0);
    checkOutput("idle_req_n", rst_req_n_out, 1);
    checkOutput("idle_cause", cause_out, 0);

    $display("[TB] scenario 2: single soft pulse");
    p0 = pulses; l0 = low_cycles; b0 = busy_cycles;
    applyStimulus(1, 0, 0, 1);
    checkOutput("soft_req_low", rst_req_n_out, 0);
    checkOutput("soft_cause", cause_out, 1);
    repeat (50) applyStimulus(1, 0, 0, 0);
    checkOutput("soft_pulse_count", pulses - p0, 1);
    checkOutput("soft_low_cycles", low_cycles - l0, P);
    checkOutput("soft_busy_cycles", busy_cycles - b0, P + H);

    $display("[TB] scenario 3: watchdog timeout");
    p0 = pulses; l0 = low_cycles;
    repeat (W + P + H + 5) applyStimulus(1, 1, 0, 0);
    checkOutput("wdg_pulse_count", pulses - p0, 1);
    checkOutput("wdg_low_cycles", low_cycles - l0, P);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] scenario 4: kicks hold off the watchdog");
    l0 = low_cycles;
    applyStimulus(1, 1, 0, 0);
    repeat (W - 1) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    for (int i = 0; i < 2000; i++) applyStimulus(1, 1, (i % 99) == 98, 0);
    checkOutput("kick_no_low", low_cycles - l0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] scenario 5: held soft request with rise during holdoff");
    p0 = pulses; l0 = low_cycles;
    repeat (20) applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    repeat (180) applyStimulus(1, 0, 0, 1);
    checkOutput("held_pulse_count", pulses - p0, 1);
    checkOutput("held_low_cycles", low_cycles - l0, P);
    applyStimulus(1, 0, 0, 0);

    $display("[TB] scenario 6: reset during pulse, warning flag");
    applyStimulus(1, 0, 0, 1);
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("trunc_req_n", rst_req_n_out, 1);
    checkOutput("trunc_busy", busy_out, 0);
    checkOutput("trunc_cause", cause_out, 0);
    repeat (60) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("warn_after_kick", wdg_warn_out, 0);
    repeat (10) applyStimulus(1, 1, 0, 0);

    $display("[TB] random phase");
    en = 1; kk = 0; ss = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      kk = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 39) == 0) ss = ~ss;
      applyStimulus($urandom_range(0, 299) != 0, en, kk, ss);
    end

    @(posedge clk_in);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
